// File: rtl/perf_pkg.sv
// rtl/perf_pkg.sv - shared constants and types for the performance counter bank
package perf_pkg;

    // Event channel assignments used by the core-side wiring
    localparam int PERF_CYCLE           = 0;
    localparam int PERF_INSTR           = 1;
    localparam int PERF_ICACHE_MISS     = 2;
    localparam int PERF_DCACHE_MISS     = 3;
    localparam int PERF_DCACHE_UNCACHED = 4;
    localparam int PERF_BRANCH          = 5;
    localparam int PERF_MISPREDICT      = 6;
    localparam int PERF_NOCF_MISPREDICT = 7;
    localparam int PERF_MM_STALL        = 8;

    localparam int PERF_NUM_CNT   = 16;
    localparam int PERF_CNT_WIDTH = 48;
    localparam int PERF_EVT_WIDTH = 2;

    // Sized for the largest bank (32 channels); narrower addresses are zero-extended
    localparam int PERF_IDX_MAX_W = 5;
    localparam int PERF_ADDR_W    = PERF_IDX_MAX_W + 1;

    typedef struct packed {
        logic [PERF_IDX_MAX_W-1:0] idx;
        logic                      half;
    } perf_rd_addr_t;

endpackage

// File: rtl/perf_counter_cell.sv
// rtl/perf_counter_cell.sv - one counter channel: counter, carry adder, sticky ovf, shadow
module perf_counter_cell #(
    parameter int CNT_WIDTH = 48,
    parameter int EVT_WIDTH = 2
) (
    input  logic                 cpu_clk,
    input  logic                 resetn,
    input  logic                 i_active,
    input  logic [EVT_WIDTH-1:0] i_inc,
    input  logic                 i_clear,
    input  logic                 i_snap,
    input  logic                 i_ovf_clr,
    output logic [CNT_WIDTH-1:0] o_shadow,
    output logic                 o_ovf
);

    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] r_shadow;
    logic                 r_ovf;
    logic [CNT_WIDTH:0]   w_sum;
    logic                 w_carry;

    assign w_sum   = {1'b0, r_cnt} + {{(CNT_WIDTH + 1 - EVT_WIDTH){1'b0}}, i_inc};
    // A cleared cycle discards the increment, so its carry is discarded too
    assign w_carry = i_active & ~i_clear & w_sum[CNT_WIDTH];

    always_ff @(posedge cpu_clk) begin
        if (!resetn) begin
            r_cnt    <= '0;
            r_shadow <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (i_clear) begin
                r_cnt <= '0;
            end else if (i_active) begin
                r_cnt <= w_sum[CNT_WIDTH-1:0];
            end
            if (i_snap) begin
                r_shadow <= r_cnt;
            end
            if (w_carry) begin
                r_ovf <= 1'b1;
            end else if (i_ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign o_shadow = r_shadow;
    assign o_ovf    = r_ovf;

endmodule

// File: rtl/perf_counter_bank.sv
// rtl/perf_counter_bank.sv - parametrised event counter bank with snapshots and windowed readback
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int NUM_CNT   = PERF_NUM_CNT,
    parameter int CNT_WIDTH = PERF_CNT_WIDTH,
    parameter int EVT_WIDTH = PERF_EVT_WIDTH,
    parameter int IDX_W     = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1
) (
    input  logic                           cpu_clk,
    input  logic                           resetn,
    input  logic [NUM_CNT*EVT_WIDTH-1:0]   evt_inc,
    input  logic [NUM_CNT-1:0]             cnt_en,
    input  logic                           freeze,
    input  logic                           clear,
    input  logic                           snap_req,
    output logic                           snap_done,
    input  logic                           rd_req,
    input  logic [IDX_W:0]                 rd_addr,
    output logic                           rd_valid,
    output logic [31:0]                    rd_data,
    output logic [NUM_CNT-1:0]             ovf,
    input  logic [NUM_CNT-1:0]             ovf_clr,
    output logic                           irq
);

    perf_rd_addr_t        w_addr;
    logic [CNT_WIDTH-1:0] w_shadow [NUM_CNT];
    logic [63:0]          w_sel;
    logic [31:0]          w_rd_word;
    logic                 r_snap_done;
    logic                 r_rd_valid;
    logic [31:0]          r_rd_data;
    logic                 r_irq;

    for (genvar g = 0; g < NUM_CNT; g++) begin : g_cell
        perf_counter_cell #(
            .CNT_WIDTH (CNT_WIDTH),
            .EVT_WIDTH (EVT_WIDTH)
        ) u_cell (
            .cpu_clk   (cpu_clk),
            .resetn    (resetn),
            .i_active  (cnt_en[g] & ~freeze),
            .i_inc     (evt_inc[g*EVT_WIDTH +: EVT_WIDTH]),
            .i_clear   (clear),
            .i_snap    (snap_req),
            .i_ovf_clr (ovf_clr[g]),
            .o_shadow  (w_shadow[g]),
            .o_ovf     (ovf[g])
        );
    end

    assign w_addr = perf_rd_addr_t'(PERF_ADDR_W'(rd_addr));

    // Indices with no matching channel fall through to zero
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (w_addr.idx == PERF_IDX_MAX_W'(i)) begin
                w_sel = 64'(w_shadow[i]);
            end
        end
    end

    assign w_rd_word = w_addr.half ? w_sel[63:32] : w_sel[31:0];

    always_ff @(posedge cpu_clk) begin
        if (!resetn) begin
            r_snap_done <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
            r_irq       <= 1'b0;
        end else begin
            r_snap_done <= snap_req;
            r_rd_valid  <= rd_req;
            r_irq       <= |ovf;
            if (rd_req) begin
                r_rd_data <= w_rd_word;
            end
        end
    end

    assign snap_done = r_snap_done;
    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;
    assign irq       = r_irq;

endmodule
